rle_stream_decompress: RTL and testbench

//  Sequential run-length bit-stream decompressor for the DCNN IO path. Consumes
//  {zero-run, one-run} tokens over valid/ready, expands them MSB-first into packed
//  OUT_W-bit words and hands the words to the output buffer over valid/ready.

---
 rtl/rle_stream_decompress.sv | 179 +++++++++++++++++
 tb/tb_rle_stream_decompress.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_decompress.sv
// rle_stream_decompress: expands {zero-run, one-run} tokens into packed OUT_W-bit
// words, MSB-first by default. Define RLE_DECOMP_LSB_FIRST_EN to fill from bit 0
// upward instead (flush padding then lands in the high bits).
module rle_stream_decompress #(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned LEN_W = 3,
    parameter int unsigned IDX_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   work,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEN_W-1:0]       in_zeros,
    input  logic [LEN_W-1:0]       in_ones,
    input  logic                   in_last,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [IDX_W-1:0]       word_idx,
    output logic [$clog2(OUT_W):0] bit_idx,
    output logic                   done
);

    localparam int unsigned BIT_W = $clog2(OUT_W) + 1;
    localparam int unsigned CNT_W = (LEN_W > BIT_W) ? LEN_W : BIT_W;
    localparam logic [OUT_W:0] ONE_W = (OUT_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN0  = 3'd1,
        S_RUN1  = 3'd2,
        S_PUSH  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  rem0_q;
    logic [LEN_W-1:0]  rem1_q;
    logic              last_pend_q;
    logic [OUT_W-1:0]  word_q;
    logic [BIT_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic              out_valid_q;
    logic              out_last_q;

    logic [LEN_W-1:0]  rem_sel;
    logic [CNT_W-1:0]  rem_ext;
    logic [BIT_W-1:0]  space;
    logic [BIT_W-1:0]  n;
    logic [LEN_W-1:0]  rem_d;
    logic [BIT_W-1:0]  bit_idx_d;
    logic [OUT_W-1:0]  mask_base;
    logic [OUT_W-1:0]  run_mask;

    // Per-cycle run step: chunk size, remaining run, new fill level and bit mask
    always_comb begin
        rem_sel   = (state_q == S_RUN1) ? rem1_q : rem0_q;
        rem_ext   = CNT_W'(rem_sel);
        space     = BIT_W'(OUT_W) - bit_idx_q;
        n         = space;
        if (rem_ext < CNT_W'(space)) begin
            n = BIT_W'(rem_ext);
        end
        rem_d     = LEN_W'(rem_ext - CNT_W'(n));
        bit_idx_d = bit_idx_q + n;
        mask_base = OUT_W'((ONE_W << n) - ONE_W);
`ifdef RLE_DECOMP_LSB_FIRST_EN
        run_mask  = mask_base << bit_idx_q;
`else
        run_mask  = mask_base << (space - n);
`endif
    end

    // Token acceptance, run expansion, word hand-off and flush sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem0_q      <= '0;
            rem1_q      <= '0;
            last_pend_q <= 1'b0;
            word_q      <= '0;
            bit_idx_q   <= '0;
            word_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (work) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        rem0_q      <= in_zeros;
                        rem1_q      <= in_ones;
                        last_pend_q <= in_last;
                        if (in_zeros != '0) begin
                            state_q <= S_RUN0;
                        end else if (in_ones != '0) begin
                            state_q <= S_RUN1;
                        end else if (in_last) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RUN0, S_RUN1: begin
                    if (state_q == S_RUN0) begin
                        word_q <= word_q & ~run_mask;
                        rem0_q <= rem_d;
                    end else begin
                        word_q <= word_q | run_mask;
                        rem1_q <= rem_d;
                    end
                    bit_idx_q <= bit_idx_d;
                    if (bit_idx_d == BIT_W'(OUT_W)) begin
                        // Word full: final only if no run bits remain after this chunk
                        state_q     <= S_PUSH;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_pend_q && (rem_d == '0) &&
                                       ((state_q == S_RUN1) || (rem1_q == '0));
                    end else if ((state_q == S_RUN0) && (rem1_q != '0)) begin
                        state_q <= S_RUN1;
                    end else if (last_pend_q) begin
                        state_q <= S_FLUSH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PUSH: begin
                    if (out_ready) begin
                        word_q      <= '0;
                        bit_idx_q   <= '0;
                        word_idx_q  <= word_idx_q + IDX_W'(1);
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            last_pend_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else if (rem0_q != '0) begin
                            state_q <= S_RUN0;
                        end else if (rem1_q != '0) begin
                            state_q <= S_RUN1;
                        end else if (last_pend_q) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_FLUSH: begin
                    // Partial word goes out zero-padded; an empty word just ends the stream
                    if (bit_idx_q != '0) begin
                        state_q     <= S_PUSH;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b1;
                    end else begin
                        last_pend_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_data  = word_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign word_idx  = word_idx_q;
    assign bit_idx   = bit_idx_q;
    // End-of-stream pulse, raised while the final state retires so it never overlaps in_ready
    assign done      = !rst && work &&
                       (((state_q == S_PUSH) && out_ready && out_last_q) ||
                        ((state_q == S_FLUSH) && (bit_idx_q == '0)));

endmodule

// File: tb/tb_rle_stream_decompress.sv
// Directed bench for rle_stream_decompress (OUT_W=8, LEN_W=3, IDX_W=32).
module tb_rle_stream_decompress;

    logic        clk = 1'b0;
    logic        rst;
    logic        work;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_zeros;
    logic [2:0]  in_ones;
    logic        in_last;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] word_idx;
    logic [3:0]  bit_idx;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [8:0] got_q[$];

    rle_stream_decompress #(.OUT_W(8), .LEN_W(3), .IDX_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .work      (work),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_zeros  (in_zeros),
        .in_ones   (in_ones),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .word_idx  (word_idx),
        .bit_idx   (bit_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected words are written MSB-first; the LSB-first build mirrors them
    function automatic logic [7:0] ew(input logic [7:0] m);
        logic [7:0] r;
`ifdef RLE_DECOMP_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = m[7-i];
`else
        r = m;
`endif
        return r;
    endfunction

    // Word/done monitor, sampled 1ns before the rising edge
    always begin
        @(negedge clk);
        #4;
        if (!rst && work && out_valid && out_ready) got_q.push_back({out_last, out_data});
        if (done) begin
            done_cnt++;
            check("done_vs_in_ready", 64'(in_ready), 64'(0));
        end
    end

    task automatic send(input logic [2:0] z, input logic [2:0] o, input logic l);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_zeros = z;
        in_ones  = o;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        exp_done++;
        while (done_cnt < exp_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_count", 64'(done_cnt), 64'(exp_done));
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic l);
        logic [8:0] w;
        if (got_q.size() != 0) w = got_q.pop_front();
        else w = 9'h1FF;
        check(tag, 64'(w), 64'({l, ew(d)}));
    endtask

    initial begin
        rst = 1'b1; work = 1'b1; in_valid = 1'b0; in_zeros = '0; in_ones = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_word_idx", 64'(word_idx), 64'(0));
        check("rst_bit_idx", 64'(bit_idx), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // {1,1,last}
        send(3'd1, 3'd1, 1'b1);
        wait_done();
        check("t1_nwords", 64'(got_q.size()), 64'(1));
        pop_check("t1_w0", 8'h40, 1'b1);
        check("t1_word_idx", 64'(word_idx), 64'(1));

        // {3,3,last}
        send(3'd3, 3'd3, 1'b1);
        wait_done();
        check("t2_nwords", 64'(got_q.size()), 64'(1));
        pop_check("t2_w0", 8'h1C, 1'b1);

        // {2,3,last}
        send(3'd2, 3'd3, 1'b1);
        wait_done();
        check("t3_nwords", 64'(got_q.size()), 64'(1));
        pop_check("t3_w0", 8'h38, 1'b1);
        check("t3_word_idx", 64'(word_idx), 64'(3));

        // {7,7,0} then {2,0,last}: run spans a word boundary
        send(3'd7, 3'd7, 1'b0);
        send(3'd2, 3'd0, 1'b1);
        wait_done();
        check("t4_nwords", 64'(got_q.size()), 64'(2));
        pop_check("t4_w0", 8'h01, 1'b0);
        pop_check("t4_w1", 8'hFC, 1'b1);
        check("t4_word_idx", 64'(word_idx), 64'(5));
        check("t4_bit_idx", 64'(bit_idx), 64'(0));

        // Backpressure: word held for 5 cycles, then exactly one hand-off
        out_ready = 1'b0;
        send(3'd7, 3'd1, 1'b0);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data", 64'(out_data), 64'(ew(8'h01)));
            check("bp_out_last", 64'(out_last), 64'(0));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_nwords", 64'(got_q.size()), 64'(1));
        pop_check("bp_w0", 8'h01, 1'b0);
        check("bp_word_idx", 64'(word_idx), 64'(6));
        check("bp_in_ready_after", 64'(in_ready), 64'(1));

        // Reset during RUN1 of {7,7,0}
        send(3'd7, 3'd7, 1'b0);
        @(negedge clk);
        check("mr_bit_idx_pre", 64'(bit_idx), 64'(7));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_out_valid", 64'(out_valid), 64'(0));
        check("mr_out_data", 64'(out_data), 64'(0));
        check("mr_out_last", 64'(out_last), 64'(0));
        check("mr_bit_idx", 64'(bit_idx), 64'(0));
        check("mr_word_idx", 64'(word_idx), 64'(0));
        @(negedge clk);
        check("mr_in_ready", 64'(in_ready), 64'(1));
        check("mr_nwords", 64'(got_q.size()), 64'(0));

        // work low freezes a token mid-flight, then it resumes exactly
        send(3'd2, 3'd3, 1'b1);
        work = 1'b0;
        repeat (4) @(negedge clk);
        check("wk_bit_idx", 64'(bit_idx), 64'(0));
        check("wk_out_valid", 64'(out_valid), 64'(0));
        check("wk_in_ready", 64'(in_ready), 64'(0));
        work = 1'b1;
        wait_done();
        check("wk_nwords", 64'(got_q.size()), 64'(1));
        pop_check("wk_w0", 8'h38, 1'b1);
        check("wk_word_idx", 64'(word_idx), 64'(1));

        // {0,0,last} with empty word: done only
        send(3'd0, 3'd0, 1'b1);
        wait_done();
        check("fl_nwords", 64'(got_q.size()), 64'(0));
        check("fl_word_idx", 64'(word_idx), 64'(1));

        // {0,0,0} is a no-op
        send(3'd0, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("nop_in_ready", 64'(in_ready), 64'(1));
        check("nop_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("nop_nwords", 64'(got_q.size()), 64'(0));

        // {7,7,last}: full word then zero-padded flush word
        send(3'd7, 3'd7, 1'b1);
        wait_done();
        check("t10_nwords", 64'(got_q.size()), 64'(2));
        pop_check("t10_w0", 8'h01, 1'b0);
        pop_check("t10_w1", 8'hFC, 1'b1);
        check("t10_word_idx", 64'(word_idx), 64'(3));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
